// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: register-programmed AXI-Stream packet generator (counter / constant / LFSR data).
// LFSR data mode is built only when AXIS_PKT_GEN_LFSR_EN is defined.
module axis_pkt_gen #(
    parameter int          DATA_W    = 64,
    parameter int          LEN_W     = 16,
    parameter logic [19:0] BASE_MASK = 20'hFFFFF
) (
    input  logic              sys_clk_i,
    input  logic              sys_rstn_i,
    input  logic [31:0]       sys_addr_i,
    input  logic [31:0]       sys_wdata_i,
    input  logic [3:0]        sys_sel_i,
    input  logic              sys_wen_i,
    input  logic              sys_ren_i,
    output logic [31:0]       sys_rdata_o,
    output logic              sys_err_o,
    output logic              sys_ack_o,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);
    localparam int LANES = DATA_W / 32;
    typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  pkt_len_q, pkt_len_d, len_q, len_d, word_q, word_d, len_eff;
    logic [31:0]       pkt_num_q, pkt_num_d, num_q, num_d, pkt_cnt_q, pkt_cnt_d;
    logic [31:0]       seed_q, seed_d, seed_run_q, seed_run_d;
    logic [31:0]       sent_q, sent_d, stall_q, stall_d, rdata_q, rd_val;
    logic [1:0]        mode_q, mode_d, mode_run_q, mode_run_d;
    logic              stop_pend_q, stop_pend_d, done_q, done_d, ack_q;
    logic [DATA_W-1:0] cnt_q, cnt_d, src;
    logic [19:0]       off;
    logic              ctrl_w, start, stop, last, unused_ok;
`ifdef AXIS_PKT_GEN_LFSR_EN
    logic [31:0]       lfsr_q, lfsr_d, lfsr_nx;
`endif

    function automatic logic [1:0] mode_fix(input logic [1:0] m);
`ifdef AXIS_PKT_GEN_LFSR_EN
        return (m == 2'd3) ? 2'd0 : m;
`else
        return (m == 2'd1) ? 2'd1 : 2'd0;
`endif
    endfunction

    assign off           = sys_addr_i[19:0] & BASE_MASK;
    assign ctrl_w        = sys_wen_i && off == 20'h0;
    assign start         = ctrl_w && sys_wdata_i[0];
    assign stop          = ctrl_w && sys_wdata_i[1];
    assign len_eff       = (pkt_len_q == '0) ? LEN_W'(1) : pkt_len_q;
    assign last          = word_q == len_q - LEN_W'(1);
    assign m_axis_tvalid = state_q == SEND;
    assign m_axis_tlast  = m_axis_tvalid && last;
    assign m_axis_tdata  = m_axis_tvalid ? src : '0;
    assign sys_ack_o     = ack_q;
    assign sys_rdata_o   = rdata_q;
    assign sys_err_o     = 1'b0;
    assign unused_ok     = &{1'b0, sys_sel_i, sys_addr_i[31:20]};

`ifdef AXIS_PKT_GEN_LFSR_EN
    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    assign lfsr_nx = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
`endif

    always_comb begin
        src = (mode_run_q == 2'd1) ? {LANES{seed_run_q}} : cnt_q;
`ifdef AXIS_PKT_GEN_LFSR_EN
        if (mode_run_q == 2'd2)
            for (int i = 0; i < LANES; i++)
                src[32*i +: 32] = (lfsr_q << i) | (lfsr_q >> (32 - i));
`endif
    end

    always_comb begin
        case (off)
            20'h00:  rd_val = {26'd0, mode_q, 4'd0};
            20'h04:  rd_val = 32'(pkt_len_q);
            20'h08:  rd_val = pkt_num_q;
            20'h0C:  rd_val = {29'd0, stop_pend_q, done_q, state_q != IDLE};
            20'h10:  rd_val = sent_q;
            20'h14:  rd_val = stall_q;
            20'h18:  rd_val = seed_q;
            default: rd_val = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pkt_len_d   = (sys_wen_i && off == 20'h04) ? sys_wdata_i[LEN_W-1:0] : pkt_len_q;
        pkt_num_d   = (sys_wen_i && off == 20'h08) ? sys_wdata_i : pkt_num_q;
        seed_d      = (sys_wen_i && off == 20'h18) ? sys_wdata_i : seed_q;
        mode_d      = ctrl_w ? mode_fix(sys_wdata_i[5:4]) : mode_q;
        mode_run_d  = mode_run_q;
        seed_run_d  = seed_run_q;
        len_d       = len_q;
        word_d      = word_q;
        num_d       = num_q;
        pkt_cnt_d   = pkt_cnt_q;
        sent_d      = sent_q;
        stall_d     = stall_q;
        stop_pend_d = stop_pend_q;
        done_d      = done_q;
        cnt_d       = cnt_q;
`ifdef AXIS_PKT_GEN_LFSR_EN
        lfsr_d      = lfsr_q;
`endif
        if (state_q == IDLE && start) begin
            state_d     = SEND;
            mode_run_d  = mode_d;
            seed_run_d  = seed_q;
            len_d       = len_eff;
            word_d      = '0;
            num_d       = pkt_num_q;
            pkt_cnt_d   = '0;
            sent_d      = '0;
            stall_d     = '0;
            stop_pend_d = 1'b0;
            done_d      = 1'b0;
            cnt_d       = '0;
`ifdef AXIS_PKT_GEN_LFSR_EN
            lfsr_d      = (seed_q == '0) ? 32'd1 : seed_q;
`endif
        end else if (state_q == SEND) begin
            if (stop)
                stop_pend_d = 1'b1;
            if (!m_axis_tready && stall_q != '1)
                stall_d = stall_q + 32'd1;
            if (m_axis_tready) begin
                cnt_d  = cnt_q + 1'b1;
                word_d = word_q + LEN_W'(1);
`ifdef AXIS_PKT_GEN_LFSR_EN
                lfsr_d = lfsr_nx;
`endif
                if (last) begin
                    word_d    = '0;
                    len_d     = len_eff;
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    sent_d    = (sent_q == '1) ? sent_q : sent_q + 32'd1;
                    // A stop written in this very cycle also ends on this last word
                    if ((num_q != '0 && pkt_cnt_q + 32'd1 == num_q) || stop_pend_q || stop)
                        state_d = FINISH;
                end
            end
        end else if (state_q == FINISH) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_q     <= IDLE;
            pkt_len_q   <= LEN_W'(256);
            pkt_num_q   <= '0;
            seed_q      <= '0;
            mode_q      <= '0;
            mode_run_q  <= '0;
            seed_run_q  <= '0;
            len_q       <= LEN_W'(1);
            word_q      <= '0;
            num_q       <= '0;
            pkt_cnt_q   <= '0;
            sent_q      <= '0;
            stall_q     <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
`ifdef AXIS_PKT_GEN_LFSR_EN
            lfsr_q      <= 32'd1;
`endif
        end else begin
            state_q     <= state_d;
            pkt_len_q   <= pkt_len_d;
            pkt_num_q   <= pkt_num_d;
            seed_q      <= seed_d;
            mode_q      <= mode_d;
            mode_run_q  <= mode_run_d;
            seed_run_q  <= seed_run_d;
            len_q       <= len_d;
            word_q      <= word_d;
            num_q       <= num_d;
            pkt_cnt_q   <= pkt_cnt_d;
            sent_q      <= sent_d;
            stall_q     <= stall_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            ack_q       <= sys_wen_i || sys_ren_i;
            rdata_q     <= sys_ren_i ? rd_val : 32'd0;
`ifdef AXIS_PKT_GEN_LFSR_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end
endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: register-table vectors plus directed and randomized packet runs against a reference model.
module tb_axis_pkt_gen;
    localparam int DW = 64;
    localparam logic [31:0] A_CTRL = 32'h00, A_LEN = 32'h04, A_NUM = 32'h08, A_STAT = 32'h0C;
    localparam logic [31:0] A_SENT = 32'h10, A_STALL = 32'h14, A_SEED = 32'h18;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [31:0]   addr = '0, wdata = '0, rdata;
    logic [3:0]    sel = 4'hF;
    logic          wen = 1'b0, ren = 1'b0, err, ack;
    logic [DW-1:0] tdata;
    logic          tvalid, tready = 1'b0, tlast;
    int            n_pass = 0, n_tot = 0;

    always #5 clk = ~clk;

    axis_pkt_gen #(.DATA_W(DW)) dut (
        .sys_clk_i(clk), .sys_rstn_i(rst_n), .sys_addr_i(addr), .sys_wdata_i(wdata),
        .sys_sel_i(sel), .sys_wen_i(wen), .sys_ren_i(ren), .sys_rdata_o(rdata),
        .sys_err_o(err), .sys_ack_o(ack), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        chk("rd_ack", ack, 1'b1);
        chk("rd_err", err, 1'b0);
        d = rdata;
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int j);
        logic [63:0] t;
        t = {x, x} << j;
        return t[63:32];
    endfunction

    // Multiply the state by x modulo x^32+x^22+x^2+x+1 (reflected bit order)
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // rdy: 0 = always ready, 1 = toggle, 2 = random; stop_at = handshake count at which STOP is written
    task automatic run(input string tag, input int len, input int num, input int mode,
                       input logic [31:0] seed, input int rdy, input int stop_at);
        logic [DW-1:0] exp_q[$];
        logic          last_q[$];
        logic [31:0]   lf, rd;
        int L, total, hs, stalls, cyc;
        bit stop_sent;
        L = (len == 0) ? 1 : len;
        total = (num == 0) ? ((stop_at / L) + 1) * L : num * L;
        lf = (seed == 0) ? 32'd1 : seed;
        for (int k = 0; k < total; k++) begin
            logic [DW-1:0] w;
            w = DW'(k);
            if (mode == 1) w = {(DW/32){seed}};
            if (mode == 2) for (int j = 0; j < DW/32; j++) w[32*j +: 32] = rotl(lf, j);
            exp_q.push_back(w);
            last_q.push_back((k % L) == L - 1);
            lf = lfsr_step(lf);
        end
        bus_wr(A_LEN, len);
        bus_wr(A_NUM, num);
        bus_wr(A_SEED, seed);
        bus_wr(A_CTRL, 32'd1 | (mode << 4));
        hs = 0; stalls = 0; cyc = 0; stop_sent = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            tready = (rdy == 0) ? 1'b1 : (rdy == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            wen = 1'b0;
            if (stop_at >= 0 && hs == stop_at && !stop_sent) begin
                addr = A_CTRL; wdata = 32'd2; wen = 1'b1; stop_sent = 1;
            end
            chk({tag, "_tvalid"}, tvalid, 1'b1);
            if (tvalid) begin
                chk($sformatf("%s_tdata%0d", tag, hs), tdata, exp_q[0]);
                chk($sformatf("%s_tlast%0d", tag, hs), tlast, last_q[0]);
                if (tready) begin
                    void'(exp_q.pop_front());
                    void'(last_q.pop_front());
                    hs++;
                end else stalls++;
            end
            @(negedge clk);
            cyc++;
        end
        wen = 1'b0;
        tready = 1'b1;
        chk({tag, "_words_left"}, exp_q.size(), 0);
        chk({tag, "_tvalid_end"}, tvalid, 1'b0);
        bus_rd(A_STAT, rd);
        chk({tag, "_status"}, rd, 32'h2);
        bus_rd(A_SENT, rd);
        chk({tag, "_pkt_sent"}, rd, total / L);
        bus_rd(A_STALL, rd);
        chk({tag, "_stall_cnt"}, rd, stalls);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        tbl[22];
        logic [31:0] rd;
`ifdef AXIS_PKT_GEN_LFSR_EN
        localparam logic [31:0] MODE2_RB = 32'h20;
        localparam int MODE_MAX = 2;
`else
        localparam logic [31:0] MODE2_RB = 32'h0;
        localparam int MODE_MAX = 1;
`endif
        tbl = '{
            '{1'b0, A_CTRL,  32'h0, 32'h0},
            '{1'b0, A_LEN,   32'h0, 32'd256},
            '{1'b0, A_NUM,   32'h0, 32'h0},
            '{1'b0, A_STAT,  32'h0, 32'h0},
            '{1'b0, A_SENT,  32'h0, 32'h0},
            '{1'b0, A_STALL, 32'h0, 32'h0},
            '{1'b0, A_SEED,  32'h0, 32'h0},
            '{1'b0, 32'h1C,  32'h0, 32'hFFFF_FFFF},
            '{1'b1, A_LEN,   32'd7, 32'h0},
            '{1'b0, A_LEN,   32'h0, 32'd7},
            '{1'b1, A_CTRL,  32'h30, 32'h0},
            '{1'b0, A_CTRL,  32'h0, 32'h0},
            '{1'b1, A_CTRL,  32'h10, 32'h0},
            '{1'b0, A_CTRL,  32'h0, 32'h10},
            '{1'b1, A_CTRL,  32'h20, 32'h0},
            '{1'b0, A_CTRL,  32'h0, MODE2_RB},
            '{1'b1, A_STAT,  32'hFF, 32'h0},
            '{1'b0, A_STAT,  32'h0, 32'h0},
            '{1'b1, A_SEED,  32'h1234_5678, 32'h0},
            '{1'b0, A_SEED,  32'h0, 32'h1234_5678},
            '{1'b1, 32'h40,  32'hDEAD, 32'h0},
            '{1'b0, 32'h40,  32'h0, 32'hFFFF_FFFF}
        };
        chk("reset_tvalid", tvalid, 1'b0);
        chk("reset_tdata", tdata, '0);
        chk("reset_ack", ack, 1'b0);
        chk("reset_rdata", rdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (tbl[i].wr) bus_wr(tbl[i].a, tbl[i].d);
            else begin
                bus_rd(tbl[i].a, rd);
                chk($sformatf("reg_vec%0d", i), rd, tbl[i].exp);
            end
        end
        bus_wr(A_CTRL, 32'h0);

        run("len4num2", 4, 2, 0, 32'h0, 0, -1);
        run("stall", 3, 2, 0, 32'h0, 1, -1);
        run("stop", 5, 0, 0, 32'h0, 0, 2);
        run("len0", 0, 3, 0, 32'h0, 0, -1);
        run("const", 2, 2, 1, 32'hA5C3_0F1E, 2, -1);
`ifdef AXIS_PKT_GEN_LFSR_EN
        run("lfsr", 4, 2, 2, 32'h0, 0, -1);
`endif
        for (int r = 0; r < 6; r++)
            run($sformatf("rand%0d", r), $urandom_range(0, 6), $urandom_range(1, 3),
                $urandom_range(0, MODE_MAX), $urandom, 2, -1);

        bus_wr(A_LEN, 32'd10);
        bus_wr(A_NUM, 32'd1);
        bus_wr(A_SEED, 32'h55);
        bus_wr(A_CTRL, 32'h1);
        tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_tvalid", tvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_tdata", tdata, '0);
        chk("rst_ack", ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(A_LEN, rd);
        chk("rst_pkt_len", rd, 32'd256);
        bus_rd(A_NUM, rd);
        chk("rst_pkt_num", rd, 32'd0);
        bus_rd(A_SEED, rd);
        chk("rst_seed", rd, 32'd0);
        bus_rd(A_STAT, rd);
        chk("rst_status", rd, 32'd0);
        chk("rst_idle_tvalid", tvalid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
